// File: rtl/scoreboard.sv
// In-order instruction scoreboard: a circular buffer of decoded entries that
// issues in program order, collects writebacks, and retires the head to commit.
package scoreboard_pkg;
   typedef enum logic [3:0] {
      FU_NONE  = 4'd0,
      FU_LOAD  = 4'd1,
      FU_STORE = 4'd2,
      FU_ALU   = 4'd3,
      FU_CTRL  = 4'd4,
      FU_MULT  = 4'd5,
      FU_CSR   = 4'd6
   } fu_t;

   typedef struct packed {
      logic [63:0] cause;
      logic [63:0] tval;
      logic        valid;
   } exception_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  trans_id;
      fu_t         fu;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [63:0] result;
      logic        valid;
      logic        use_imm;
      logic        use_pc;
      exception_t  ex;
   } scoreboard_entry;
endpackage

module scoreboard
   import scoreboard_pkg::*;
#(
   parameter int NR_ENTRIES = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            flush_i,
   input  scoreboard_entry decoded_instr_i,
   input  logic            decoded_valid_i,
   output logic            decoded_ready_o,
   output scoreboard_entry issue_instr_o,
   output logic            issue_valid_o,
   input  logic            issue_ack_i,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_trans_id_i,
   input  logic [63:0]     wb_result_i,
   input  exception_t      wb_ex_i,
   output scoreboard_entry commit_instr_o,
   output logic            commit_valid_o,
   input  logic            commit_ack_i,
   output logic [31:0]     rd_busy_o
);
   localparam int PTR_W = $clog2(NR_ENTRIES);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(NR_ENTRIES);

   scoreboard_entry  mem [NR_ENTRIES];
   logic [PTR_W-1:0] commit_ptr, issue_ptr, decode_ptr;
   logic [CNT_W-1:0] count, unissued, issued_cnt;

   scoreboard_entry  new_entry;
   logic             dec_fire, iss_fire, wb_fire, com_fire;
   logic [PTR_W-1:0] wb_slot, wb_ofs;
   logic [31:0]      busy;

   assign decoded_ready_o = (count < FULL);
   assign issue_valid_o   = (unissued != '0);
   assign issue_instr_o   = mem[issue_ptr];
   assign commit_instr_o  = mem[commit_ptr];
   assign commit_valid_o  = (count != '0) && mem[commit_ptr].valid;
   assign rd_busy_o       = busy;

   assign dec_fire   = decoded_valid_i && decoded_ready_o;
   assign iss_fire   = issue_ack_i && issue_valid_o;
   assign com_fire   = commit_ack_i && commit_valid_o;
   assign issued_cnt = count - unissued;

   // A writeback is only honoured for slots that are issued but not yet retired.
   assign wb_slot = wb_trans_id_i[PTR_W-1:0];
   assign wb_ofs  = wb_slot - commit_ptr;
   assign wb_fire = wb_valid_i
                    && ({1'b0, wb_trans_id_i} < 6'(NR_ENTRIES))
                    && ({1'b0, wb_ofs} < issued_cnt);

   always_comb begin
      new_entry          = decoded_instr_i;
      new_entry.trans_id = 5'(decode_ptr);
      new_entry.result   = '0;
      new_entry.valid    = decoded_instr_i.ex.valid || (decoded_instr_i.fu == FU_NONE);
   end

   always_comb begin
      busy = '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
         if (CNT_W'(i) < issued_cnt) busy[mem[commit_ptr + PTR_W'(i)].rd] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         commit_ptr <= '0;
         issue_ptr  <= '0;
         decode_ptr <= '0;
         count      <= '0;
         unissued   <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) mem[i] <= '0;
      end else if (flush_i) begin
         commit_ptr <= '0;
         issue_ptr  <= '0;
         decode_ptr <= '0;
         count      <= '0;
         unissued   <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) mem[i].valid <= 1'b0;
      end else begin
         if (dec_fire) begin
            mem[decode_ptr] <= new_entry;
            decode_ptr      <= decode_ptr + PTR_W'(1);
         end
         if (iss_fire) issue_ptr <= issue_ptr + PTR_W'(1);
         if (wb_fire) begin
            mem[wb_slot].result <= wb_result_i;
            mem[wb_slot].valid  <= 1'b1;
            if (wb_ex_i.valid) mem[wb_slot].ex <= wb_ex_i;
         end
         if (com_fire) begin
            mem[commit_ptr].valid <= 1'b0;
            commit_ptr            <= commit_ptr + PTR_W'(1);
         end
         count    <= count + CNT_W'(dec_fire) - CNT_W'(com_fire);
         unissued <= unissued + CNT_W'(dec_fire) - CNT_W'(iss_fire);
      end
   end
endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: fill, ordered issue/commit, wrap-around,
// exception paths, flush and asynchronous reset.
module tb_scoreboard;
   import scoreboard_pkg::*;

   logic            clk = 1'b0;
   logic            rst, flush;
   scoreboard_entry decoded_instr, issue_instr, commit_instr;
   logic            decoded_valid, decoded_ready, issue_valid, issue_ack;
   logic            wb_valid, commit_valid, commit_ack;
   logic [4:0]      wb_trans_id;
   logic [63:0]     wb_result;
   exception_t      wb_ex;
   logic [31:0]     rd_busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_dec, n_iss, n_wb, n_com;

   scoreboard #(.NR_ENTRIES(8)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .decoded_instr_i(decoded_instr), .decoded_valid_i(decoded_valid),
      .decoded_ready_o(decoded_ready),
      .issue_instr_o(issue_instr), .issue_valid_o(issue_valid), .issue_ack_i(issue_ack),
      .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
      .wb_ex_i(wb_ex),
      .commit_instr_o(commit_instr), .commit_valid_o(commit_valid),
      .commit_ack_i(commit_ack), .rd_busy_o(rd_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush         = 1'b0;
      decoded_valid = 1'b0;
      issue_ack     = 1'b0;
      wb_valid      = 1'b0;
      wb_trans_id   = '0;
      wb_result     = '0;
      wb_ex         = '0;
      commit_ack    = 1'b0;
   endtask

   // Garbage in trans_id/result/valid proves the scoreboard overwrites them.
   function automatic scoreboard_entry mk(input logic [4:0] rd, input fu_t fu,
                                          input logic exv, input logic [63:0] cause);
      scoreboard_entry e;
      e          = '0;
      e.pc       = 64'h8000_0000 + {59'd0, rd};
      e.rd       = rd;
      e.fu       = fu;
      e.trans_id = 5'h1f;
      e.result   = 64'hBAD;
      e.valid    = 1'b1;
      e.ex.valid = exv;
      e.ex.cause = cause;
      return e;
   endfunction

   task automatic reset_outputs(input string tag);
      check({tag, "_ready"}, 64'(decoded_ready), 64'd1);
      check({tag, "_issue_valid"}, 64'(issue_valid), 64'd0);
      check({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
      check({tag, "_rd_busy"}, 64'(rd_busy), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      decoded_instr = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_outputs("reset");

      // Fill to full
      for (int i = 0; i < 8; i++) begin
         check("fill_ready", 64'(decoded_ready), 64'd1);
         decoded_valid = 1'b1;
         decoded_instr = mk(5'(i + 1), FU_ALU, 1'b0, 64'd0);
         tick();
      end
      check("full_ready", 64'(decoded_ready), 64'd0);
      decoded_instr = mk(5'd9, FU_ALU, 1'b0, 64'd0);
      tick();
      decoded_valid = 1'b0;
      check("full_ready_held", 64'(decoded_ready), 64'd0);

      // Issue order and busy bits
      for (int i = 0; i < 8; i++) begin
         check("iss_valid", 64'(issue_valid), 64'd1);
         check("iss_trans_id", 64'(issue_instr.trans_id), 64'(i));
         check("iss_rd", 64'(issue_instr.rd), 64'(i + 1));
         issue_ack = 1'b1;
         tick();
      end
      issue_ack = 1'b0;
      check("no_ninth_entry", 64'(issue_valid), 64'd0);
      check("busy_all", 64'(rd_busy), 64'h1FE);
      wb_valid = 1'b1; wb_trans_id = 5'd3; wb_result = 64'hDEAD;
      tick();
      wb_valid = 1'b0;
      check("head_not_valid", 64'(commit_valid), 64'd0);

      // In-order commit
      for (int i = 0; i < 3; i++) begin
         wb_valid = 1'b1; wb_trans_id = 5'(i); wb_result = 64'h100 + 64'(i);
         tick();
      end
      wb_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("com_valid", 64'(commit_valid), 64'd1);
         check("com_trans_id", 64'(commit_instr.trans_id), 64'(i));
         check("com_result", commit_instr.result, (i == 3) ? 64'hDEAD : 64'h100 + 64'(i));
         commit_ack = 1'b1;
         tick();
         if (i == 0) check("ready_after_commit", 64'(decoded_ready), 64'd1);
      end
      commit_ack = 1'b0;
      check("com_stop", 64'(commit_valid), 64'd0);
      check("busy_after_commit", 64'(rd_busy), 64'h1E0);

      flush = 1'b1;
      tick();
      flush = 1'b0;
      reset_outputs("flush1");

      // Wrap-around: decode, issue, writeback and commit overlap every cycle
      n_dec = 0; n_iss = 0; n_wb = 0; n_com = 0;
      for (int cyc = 0; cyc < 80 && n_com < 20; cyc++) begin
         automatic logic dec_acc = 1'b0;
         automatic logic iss_acc = issue_valid;
         automatic logic com_acc = commit_valid;
         automatic logic wb_go   = (n_wb < n_iss);
         decoded_valid = (n_dec < 20);
         decoded_instr = mk(5'((n_dec % 31) + 1), FU_ALU, 1'b0, 64'd0);
         dec_acc       = decoded_valid && decoded_ready;
         issue_ack     = iss_acc;
         if (iss_acc) check("wrap_iss_id", 64'(issue_instr.trans_id), 64'(n_iss % 8));
         wb_valid    = wb_go;
         wb_trans_id = 5'(n_wb % 8);
         wb_result   = 64'h5000 + 64'(n_wb);
         commit_ack  = com_acc;
         if (com_acc) begin
            check("wrap_com_id", 64'(commit_instr.trans_id), 64'(n_com % 8));
            check("wrap_com_res", commit_instr.result, 64'h5000 + 64'(n_com));
         end
         tick();
         if (dec_acc) n_dec++;
         if (iss_acc) n_iss++;
         if (wb_go)   n_wb++;
         if (com_acc) n_com++;
      end
      idle();
      check("wrap_issued", 64'(n_iss), 64'd20);
      check("wrap_committed", 64'(n_com), 64'd20);
      check("wrap_drained_iss", 64'(issue_valid), 64'd0);
      check("wrap_drained_com", 64'(commit_valid), 64'd0);

      // Exception raised at decode: retireable without writeback
      decoded_valid = 1'b1;
      decoded_instr = mk(5'd7, FU_ALU, 1'b1, 64'd5);
      tick();
      decoded_valid = 1'b0;
      check("dex_commit_valid", 64'(commit_valid), 64'd1);
      check("dex_trans_id", 64'(commit_instr.trans_id), 64'd4);
      check("dex_cause", commit_instr.ex.cause, 64'd5);
      check("dex_ex_valid", 64'(commit_instr.ex.valid), 64'd1);
      issue_ack = 1'b1; commit_ack = 1'b1;
      tick();
      idle();

      // Writeback to an unissued slot is dropped; exception from the unit is kept
      decoded_valid = 1'b1;
      decoded_instr = mk(5'd3, FU_ALU, 1'b0, 64'd0);
      tick();
      decoded_valid = 1'b0;
      wb_valid = 1'b1; wb_trans_id = 5'd5; wb_result = 64'h99;
      tick();
      wb_valid = 1'b0;
      check("wb_unissued_ignored", 64'(commit_valid), 64'd0);
      issue_ack = 1'b1;
      tick();
      issue_ack = 1'b0;
      check("busy_rd3", 64'(rd_busy), 64'h8);
      wb_valid = 1'b1; wb_trans_id = 5'd5; wb_result = 64'h77;
      wb_ex = '{cause: 64'd2, tval: 64'h1234, valid: 1'b1};
      tick();
      idle();
      check("wbex_commit_valid", 64'(commit_valid), 64'd1);
      check("wbex_trans_id", 64'(commit_instr.trans_id), 64'd5);
      check("wbex_cause", commit_instr.ex.cause, 64'd2);
      check("wbex_result", commit_instr.result, 64'h77);
      commit_ack = 1'b1;
      tick();
      commit_ack = 1'b0;
      check("wbex_busy_clear", 64'(rd_busy), 64'd0);

      // Flush with 5 entries and simultaneous decode/writeback/commit
      for (int i = 0; i < 5; i++) begin
         decoded_valid = 1'b1;
         decoded_instr = mk(5'(10 + i), FU_ALU, 1'b0, 64'd0);
         tick();
      end
      decoded_valid = 1'b0;
      issue_ack = 1'b1;
      repeat (3) tick();
      issue_ack = 1'b0;
      wb_valid = 1'b1; wb_trans_id = 5'd6; wb_result = 64'h66;
      tick();
      wb_valid = 1'b0;
      check("pre_flush_commit_valid", 64'(commit_valid), 64'd1);
      check("pre_flush_busy", 64'(rd_busy), 64'h1C00);
      flush = 1'b1;
      decoded_valid = 1'b1; decoded_instr = mk(5'd20, FU_ALU, 1'b0, 64'd0);
      wb_valid = 1'b1; wb_trans_id = 5'd7; wb_result = 64'h67;
      commit_ack = 1'b1;
      tick();
      idle();
      reset_outputs("flush2");
      decoded_valid = 1'b1;
      decoded_instr = mk(5'd21, FU_ALU, 1'b0, 64'd0);
      tick();
      decoded_valid = 1'b0;
      check("post_flush_iss_valid", 64'(issue_valid), 64'd1);
      check("post_flush_trans_id", 64'(issue_instr.trans_id), 64'd0);
      check("post_flush_rd", 64'(issue_instr.rd), 64'd21);
      issue_ack = 1'b1;
      tick();
      issue_ack = 1'b0;
      check("post_flush_single", 64'(issue_valid), 64'd0);

      // Asynchronous reset mid-cycle
      decoded_valid = 1'b1;
      decoded_instr = mk(5'd5, FU_NONE, 1'b0, 64'd0);
      wb_valid = 1'b1; wb_trans_id = 5'd0; wb_result = 64'h42;
      tick();
      idle();
      check("pre_rst_commit_valid", 64'(commit_valid), 64'd1);
      check("pre_rst_issue_valid", 64'(issue_valid), 64'd1);
      check("pre_rst_busy", 64'(rd_busy), 64'h20_0000);
      #2 rst = 1'b1;
      #1;
      reset_outputs("async_rst");
      #1 rst = 1'b0;
      tick();
      reset_outputs("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/scoreboard.md
Name: scoreboard

Overview:
- In-order circular buffer of `scoreboard_entry` records between decode and the issue/execute units; also feeds commit.
- Accepts decoded instructions and stamps each with its slot index as `trans_id`.
- Offers instructions to issue in program order, records functional-unit writeback results/exceptions, and retires entries in order to commit.
- Sits directly downstream of decode, which produces `scoreboard_entry`.

Parameters:
- NR_ENTRIES, 8, number of slots; power of two, 2..32 (`trans_id` is 5 bits).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- flush_i  input  1  discard all entries (mispredict/exception).
- decoded_instr_i  input  scoreboard_entry (291)  instruction from decode; incoming `trans_id`/`result`/`valid` are ignored.
- decoded_valid_i  input  1  decode offers an instruction.
- decoded_ready_o  output  1  a slot is free.
- issue_instr_o  output  scoreboard_entry  oldest not-yet-issued entry.
- issue_valid_o  output  1  `issue_instr_o` is meaningful.
- issue_ack_i  input  1  issue consumed `issue_instr_o`.
- wb_valid_i  input  1  functional-unit writeback.
- wb_trans_id_i  input  5  slot being written back.
- wb_result_i  input  64  result data.
- wb_ex_i  input  exception (129)  exception raised by the functional unit.
- commit_instr_o  output  scoreboard_entry  head (oldest) entry.
- commit_valid_o  output  1  head entry is occupied and has `valid=1`.
- commit_ack_i  input  1  commit retires the head.
- rd_busy_o  output  32  bit r set when an issued, uncommitted entry has `rd==r` and r!=0.

Behaviour:
- **State:**
  - Slot array `mem[NR_ENTRIES]`.
  - Pointers `commit_ptr` (head), `issue_ptr`, `decode_ptr` (tail), each log2(NR_ENTRIES) bits, wrapping modulo NR_ENTRIES.
  - Occupancy counter `count` (0..NR_ENTRIES).
  - Invariant: `issue_ptr` lies between `commit_ptr` and `decode_ptr` inclusive.
- **Reset (`rst_i` high, async):**
  - Pointers = 0, `count` = 0, all slot `valid` bits = 0.
  - Outputs: `decoded_ready_o`=1, `issue_valid_o`=0, `commit_valid_o`=0, `rd_busy_o`=0.
  - `issue_instr_o` and `commit_instr_o` are don't-care while their valid bit is 0.
  - Reset mid-operation drops all content immediately.
- **Decode:**
  - `decoded_ready_o` = (`count` < NR_ENTRIES). It depends on registered state only; no combinational path from `commit_ack_i`.
  - On `decoded_valid_i & decoded_ready_o`: write `mem[decode_ptr]` = `decoded_instr_i` with `trans_id` = `decode_ptr`.
  - `valid` is set to 1 if `decoded_instr_i.ex.valid` or `fu==NONE`, else 0. `result` = 0.
  - `decode_ptr`++.
  - Entry is visible on the issue port the next cycle.
- **Issue:**
  - `issue_valid_o` = (`issue_ptr` != `decode_ptr`) or (`count`==NR_ENTRIES and `issue_ptr`==`commit_ptr` and no entry issued).
  - Use a separate `unissued` counter to disambiguate full vs empty.
  - `issue_instr_o` = `mem[issue_ptr]`.
  - On `issue_ack_i & issue_valid_o`: `issue_ptr`++.
  - `issue_ack_i` without `issue_valid_o` is ignored.
- **Writeback:**
  - On `wb_valid_i`: `mem[wb_trans_id_i].result` = `wb_result_i`, `.valid` = 1.
  - If `wb_ex_i.valid`, also `.ex` = `wb_ex_i`.
  - Writeback to a slot that is not issued-and-uncommitted is ignored; the bench flags it as a protocol error.
  - Result is visible on commit the next cycle.
- **Commit:**
  - `commit_valid_o` = (`count`>0) & `mem[commit_ptr].valid`.
  - `commit_instr_o` = `mem[commit_ptr]`.
  - On `commit_ack_i & commit_valid_o`: clear slot `valid`, `commit_ptr`++.
- **Count:** `count` += accepted decode − accepted commit. Decode and commit in the same cycle leave `count` unchanged.
  - When full, a same-cycle commit does not enable a decode accept that cycle (ready is registered).
- **Simultaneous events on one slot:**
  - Writeback and issue on the same slot cannot occur, since writeback requires a prior issue.
  - A decode write to a slot being committed cannot occur, since the slot is occupied.
- **Flush (synchronous):**
  - Priority over decode, issue, writeback and commit in the same cycle.
  - Next cycle: pointers = 0, `count` = 0, all `valid` = 0. Outputs take their reset values.
- **`rd_busy_o`:** combinational OR over slots from `commit_ptr` (inclusive) to `issue_ptr` (exclusive) of one-hot(`rd`). Bit 0 is forced to 0.

Test Plan:
- **Fill to full:** push 8 instrs (`rd`=1..8), no issue/commit → `trans_id` 0..7 in order; `decoded_ready_o`=0 after the 8th accept; a 9th `decoded_valid_i` is held off.
- **Issue order and busy bits:** issue all 8, then writeback `trans_id` 3 (`result`=0xDEAD) → `commit_valid_o` stays 0 (head=0 not valid); `rd_busy_o`=0x1FE.
- **In-order commit:** writeback 0,1,2 → commit retires 0,1,2,3 on consecutive acks with correct results; `rd_busy_o` bits 1..4 clear; `decoded_ready_o`=1 the cycle after the first commit.
- **Wrap-around:** 20 back-to-back instructions with same-cycle decode, issue, writeback and commit → `trans_id` sequence 0..7,0..7,0..3; no loss or duplication; `count` stays ≤8.
- **Exception paths:** decode entry with `ex.valid`=1 → `commit_valid_o` without writeback, `ex` preserved. Writeback with `wb_ex_i.valid`, `cause`=2 → committed entry carries `cause`=2.
- **Flush and reset:** flush asserted with 5 entries and simultaneous decode/writeback/commit → next cycle all outputs at reset values, the accepted decode is discarded. Async `rst_i` pulse mid-cycle → outputs reset immediately.
